// File: rtl/mmio_timer_cmp.sv
// Memory-mapped machine timer: writable 64-bit mtime with enable and
// prescaler, plus NUM_CMP compare channels each driving a level interrupt.
// Reads are combinational; writes are byte-merged and commit on the edge.
module mmio_timer_cmp #(
  parameter logic [63:0] BASE_ADDR = 64'hb000_0000,
  parameter int          NUM_CMP   = 2,
  parameter int          DIV_W     = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               ren,
  input  logic [63:0]        raddr,
  output logic [63:0]        rdata,
  input  logic               wen,
  input  logic [63:0]        waddr,
  input  logic [63:0]        wdata,
  input  logic [7:0]         wstrb,
  output logic               tick,
  output logic [NUM_CMP-1:0] irq
);

  // Byte-lane merge of new write data over an existing register value.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [7:0]  strb);
    logic [63:0] r;
    r = old_v;
    for (int k = 0; k < 8; k++) begin
      if (strb[k]) r[8*k +: 8] = new_v[8*k +: 8];
    end
    return r;
  endfunction

  // Architectural state
  logic [63:0]      mtime_reg, mtime_next;
  logic             en_reg, en_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [DIV_W-1:0] pc_reg, pc_next;
  logic             tick_reg, tick_next;
  logic [NUM_CMP-1:0] irq_reg, irq_next;
  logic [63:0]      cmp_reg  [NUM_CMP];
  logic [63:0]      cmp_next [NUM_CMP];

  // Address decode: word index relative to the window base. Addresses below
  // the base wrap to huge indices and therefore decode as unmapped.
  logic [63:0] roff, woff;
  logic [60:0] ridx, widx;
  logic        wact, mtime_wr, ctrl_wr;
  logic [NUM_CMP-1:0] cmp_wr;
  logic [63:0] ctrl_word, ctrl_merged;
  logic [63:0] cmp_rsel [NUM_CMP];
  logic        inc;

  assign roff     = raddr - BASE_ADDR;
  assign woff     = waddr - BASE_ADDR;
  assign ridx     = roff[63:3];
  assign widx     = woff[63:3];
  // A write with no byte lanes enabled is a complete no-op, including its
  // side effects on the prescaler.
  assign wact     = wen && (wstrb != 8'h00);
  assign mtime_wr = wact && (widx == 61'd0);
  assign ctrl_wr  = wact && (widx == 61'd1);
  assign inc      = en_reg && (pc_reg == div_reg);

  // CTRL as seen by software: EN in bit 0, DIV at bit 16, all else zero.
  always_comb begin
    ctrl_word = '0;
    ctrl_word[0] = en_reg;
    ctrl_word[16 +: DIV_W] = div_reg;
  end

  assign ctrl_merged = merge_bytes(ctrl_word, wdata, wstrb);

  // Next-state for counter, prescaler and control; software writes win.
  always_comb begin
    mtime_next = mtime_reg;
    pc_next    = pc_reg;
    en_next    = en_reg;
    div_next   = div_reg;
    if (en_reg) begin
      pc_next = inc ? '0 : pc_reg + DIV_W'(1);
    end
    if (inc) begin
      mtime_next = mtime_reg + 64'd1;
    end
    if (ctrl_wr) begin
      en_next  = ctrl_merged[0];
      div_next = ctrl_merged[16 +: DIV_W];
      if (ctrl_merged[16 +: DIV_W] != div_reg) pc_next = '0;
    end
    if (mtime_wr) begin
      mtime_next = merge_bytes(mtime_reg, wdata, wstrb);
      pc_next    = '0;
    end
    tick_next = inc && !mtime_wr;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CMP; gi++) begin : g_cmp
      assign cmp_wr[gi]   = wact && (widx == 61'(2 + gi));
      assign cmp_next[gi] = cmp_wr[gi] ? merge_bytes(cmp_reg[gi], wdata, wstrb)
                                       : cmp_reg[gi];
      // Compare against post-edge values so irq tracks the new state at once.
      assign irq_next[gi] = (mtime_next >= cmp_next[gi]);
      assign cmp_rsel[gi] = (ridx == 61'(2 + gi)) ? cmp_reg[gi] : 64'd0;

      // Compare register; resets to all ones so no interrupt fires by default.
      always_ff @(posedge clk) begin
        if (!rstn) cmp_reg[gi] <= '1;
        else       cmp_reg[gi] <= cmp_next[gi];
      end
    end
  endgenerate

  // Timer, control, tick and interrupt state registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mtime_reg <= '0;
      en_reg    <= 1'b1;
      div_reg   <= '0;
      pc_reg    <= '0;
      tick_reg  <= 1'b0;
      irq_reg   <= '0;
    end else begin
      mtime_reg <= mtime_next;
      en_reg    <= en_next;
      div_reg   <= div_next;
      pc_reg    <= pc_next;
      tick_reg  <= tick_next;
      irq_reg   <= irq_next;
    end
  end

  // Combinational read mux returning pre-edge values; zero when unmapped.
  always_comb begin
    rdata = '0;
    if (ren) begin
      if (ridx == 61'd0)      rdata = mtime_reg;
      else if (ridx == 61'd1) rdata = ctrl_word;
      else begin
        for (int i = 0; i < NUM_CMP; i++) rdata = rdata | cmp_rsel[i];
      end
    end
  end

  assign tick = tick_reg;
  assign irq  = irq_reg;

endmodule

// File: tb/tb_mmio_timer_cmp.sv
// Directed bench for mmio_timer_cmp with hand-computed expectations.
module tb_mmio_timer_cmp;

  localparam logic [63:0] BASE  = 64'hb000_0000;
  localparam logic [63:0] A_MT  = BASE + 64'h00;
  localparam logic [63:0] A_CT  = BASE + 64'h08;
  localparam logic [63:0] A_C0  = BASE + 64'h10;
  localparam logic [63:0] A_C1  = BASE + 64'h18;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ren;
  logic [63:0] raddr;
  logic [63:0] rdata;
  logic        wen;
  logic [63:0] waddr;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        tick;
  logic [1:0]  irq;

  int tests_run = 0;
  int tests_failed = 0;
  logic [63:0] d;

  mmio_timer_cmp #(.BASE_ADDR(BASE), .NUM_CMP(2), .DIV_W(16)) dut (
    .clk(clk), .rstn(rstn), .ren(ren), .raddr(raddr), .rdata(rdata),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .tick(tick), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [63:0] a, output logic [63:0] v);
    ren = 1'b1;
    raddr = a;
    #1;
    v = rdata;
    ren = 1'b0;
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] v, input logic [7:0] s);
    wen = 1'b1;
    waddr = a;
    wdata = v;
    wstrb = s;
    step();
    wen = 1'b0;
    wstrb = 8'h00;
  endtask

  initial begin
    rstn = 1'b0; ren = 1'b0; raddr = '0; wen = 1'b0;
    waddr = '0; wdata = '0; wstrb = '0;

    // Reset state
    repeat (3) step();
    rd(A_MT, d); check("rst_mtime", d, 64'd0);
    check("rst_irq", {62'd0, irq}, 64'd0);
    check("rst_tick", {63'd0, tick}, 64'd0);
    rstn = 1'b1;
    repeat (10) step();
    rd(A_MT, d); check("idle10_mtime", d, 64'd10);
    check("idle_tick", {63'd0, tick}, 64'd1);
    rd(A_CT, d); check("rst_ctrl", d, 64'h1);
    rd(A_C0, d); check("rst_cmp0", d, 64'hFFFF_FFFF_FFFF_FFFF);
    check("idle_irq", {62'd0, irq}, 64'd0);

    // DIV=3: write edge still increments with the old DIV=0 (10 -> 11)
    wr(A_CT, 64'h0003_0001, 8'hFF);
    rd(A_MT, d); check("div_wr_mtime", d, 64'd11);
    rd(A_CT, d); check("div_ctrl_rd", d, 64'h0003_0001);
    for (int k = 1; k <= 40; k++) begin
      step();
      check($sformatf("div3_tick_%0d", k), {63'd0, tick}, {63'd0, (k % 4 == 0)});
    end
    rd(A_MT, d); check("div3_mtime_40", d, 64'd21);

    // MTIME write on the edge an increment is due; read shows old value
    repeat (3) step();
    ren = 1'b1; raddr = A_MT;
    wen = 1'b1; waddr = A_MT; wdata = 64'd100; wstrb = 8'hFF;
    #1;
    check("rw_same_old", rdata, 64'd21);
    step();
    wen = 1'b0; wstrb = 8'h00; ren = 1'b0;
    rd(A_MT, d); check("mtw_mtime", d, 64'd100);
    check("mtw_no_tick", {63'd0, tick}, 64'd0);
    repeat (3) step();
    rd(A_MT, d); check("mtw_hold", d, 64'd100);
    step();
    rd(A_MT, d); check("mtw_period", d, 64'd101);
    check("mtw_tick", {63'd0, tick}, 64'd1);

    // Compare channel 1
    wr(A_CT, 64'h1, 8'hFF);
    wr(A_C1, 64'd50, 8'hFF);
    wr(A_MT, 64'd45, 8'hFF);
    check("cmp_irq_45", {62'd0, irq}, 64'd0);
    repeat (4) step();
    rd(A_MT, d); check("cmp_mtime_49", d, 64'd49);
    check("cmp_irq_49", {62'd0, irq}, 64'd0);
    step();
    rd(A_MT, d); check("cmp_mtime_50", d, 64'd50);
    check("cmp_irq_50", {62'd0, irq}, 64'd2);
    step();
    check("cmp_irq_51", {62'd0, irq}, 64'd2);
    wr(A_C1, 64'd1000, 8'hFF);
    check("cmp_irq_clr", {62'd0, irq}, 64'd0);

    // Byte strobes
    wr(A_C0, 64'hDEAD_BEEF_1234_5678, 8'h0F);
    rd(A_C0, d); check("strb_cmp0", d, 64'hFFFF_FFFF_1234_5678);
    wr(A_C0, 64'd0, 8'h00);
    rd(A_C0, d); check("strb0_noop", d, 64'hFFFF_FFFF_1234_5678);
    check("strb_irq", {62'd0, irq}, 64'd0);

    // Wrap-around
    wr(A_MT, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    rd(A_MT, d); check("wrap_fe", d, 64'hFFFF_FFFF_FFFF_FFFE);
    check("wrap_irq_hi", {62'd0, irq}, 64'd3);
    step();
    rd(A_MT, d); check("wrap_ff", d, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    rd(A_MT, d); check("wrap_zero", d, 64'd0);
    check("wrap_irq_lo", {62'd0, irq}, 64'd0);
    rd(BASE + 64'h40, d); check("unmapped_40", d, 64'd0);
    rd(BASE + 64'h20, d); check("unmapped_20", d, 64'd0);
    rd(64'h1000, d); check("outside", d, 64'd0);
    ren = 1'b0; raddr = A_MT; #1;
    check("ren_low", rdata, 64'd0);

    // Disable: write edge still counts with EN=1 (0 -> 1), then hold
    wr(A_CT, 64'h0, 8'hFF);
    rd(A_MT, d); check("en0_mtime", d, 64'd1);
    repeat (2) step();
    rd(A_MT, d); check("en0_hold", d, 64'd1);
    check("en0_tick", {63'd0, tick}, 64'd0);
    wr(A_CT, 64'h1, 8'hFF);
    repeat (2) step();
    rd(A_MT, d); check("en1_resume", d, 64'd3);

    // Reset mid-count with a concurrent write that must not commit
    rstn = 1'b0;
    wen = 1'b1; waddr = A_MT; wdata = 64'd555; wstrb = 8'hFF;
    step();
    wen = 1'b0; wstrb = 8'h00;
    rd(A_MT, d); check("mid_rst_mtime", d, 64'd0);
    rd(A_CT, d); check("mid_rst_ctrl", d, 64'h1);
    rd(A_C1, d); check("mid_rst_cmp1", d, 64'hFFFF_FFFF_FFFF_FFFF);
    check("mid_rst_irq", {62'd0, irq}, 64'd0);
    rstn = 1'b1;
    step();
    rd(A_MT, d); check("post_rst_mtime", d, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
